// File: rtl/axi4_lite_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_master
//   Single-outstanding AXI4-Lite initiator. A simple command/response handshake
//   (cmd_* / rsp_*) is turned into one AXI4-Lite write or read transaction at a
//   time. Intended for on-chip engines (pattern generator, frame loader) that
//   write and read back pixels in the LED frame RAM without a CPU.
//
// Ports
//   axi_clk, axi_rst        clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_ready is high only when idle
//   cmd_wr                  1 = write, 0 = read
//   cmd_addr/wdata/wstrb    byte address, write data, write byte strobes
//   rsp_valid/rsp_ready     response handshake; rsp_* held until consumed
//   rsp_rdata/resp/wr       read data (0 for writes), BRESP/RRESP, write flag
//   timeout                 sticky: current/most recent transaction overran
//   axi4l_m_*               AXI4-Lite master channels AW, W, B, AR, R
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module axi4_lite_master #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_wr,
  output logic              timeout,
  output logic [ADDR_W-1:0] axi4l_m_awaddr,
  output logic [2:0]        axi4l_m_awprot,
  output logic              axi4l_m_awvalid,
  input  logic              axi4l_m_awready,
  output logic [DATA_W-1:0] axi4l_m_wdata,
  output logic [3:0]        axi4l_m_wstrb,
  output logic              axi4l_m_wvalid,
  input  logic              axi4l_m_wready,
  input  logic [1:0]        axi4l_m_bresp,
  input  logic              axi4l_m_bvalid,
  output logic              axi4l_m_bready,
  output logic [ADDR_W-1:0] axi4l_m_araddr,
  output logic [2:0]        axi4l_m_arprot,
  output logic              axi4l_m_arvalid,
  input  logic              axi4l_m_arready,
  input  logic [DATA_W-1:0] axi4l_m_rdata,
  input  logic [1:0]        axi4l_m_rresp,
  input  logic              axi4l_m_rvalid,
  output logic              axi4l_m_rready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [2:0]        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              aw_done, w_done;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_wr_d    = rsp_wr_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    // A channel counts as done once its valid has been accepted and dropped,
    // or if it is being accepted this cycle.
    aw_done     = !awvalid_q || axi4l_m_awready;
    w_done      = !wvalid_q  || axi4l_m_wready;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          timeout_d   = 1'b0;
          // The counter holds the 1-based index of the busy cycle in progress.
          cnt_d       = CNT_W'(1);
          if (cmd_wr) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && axi4l_m_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi4l_m_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi4l_m_bvalid && bready_q) begin
          rsp_resp_d  = axi4l_m_bresp;
          rsp_wr_d    = 1'b1;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_RD_REQ: begin
        if (arvalid_q && axi4l_m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (axi4l_m_rvalid && rready_q) begin
          rsp_rdata_d = axi4l_m_rdata;
          rsp_resp_d  = axi4l_m_rresp;
          rsp_wr_d    = 1'b0;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_q = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
             (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
    busy_d = (state_d == S_WR_REQ) || (state_d == S_WR_RESP) ||
             (state_d == S_RD_REQ) || (state_d == S_RD_RESP);

    if (busy_q && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    // Registered flag is high during busy cycle k whenever k >= TIMEOUT_CYCLES,
    // so it is computed from the index of the cycle about to start.
    if (busy_q && busy_d && cnt_d >= CNT_MAX) timeout_d = 1'b1;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_wr_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_wr_q    <= rsp_wr_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;
  assign rsp_wr          = rsp_wr_q;
  assign timeout         = timeout_q;
  assign axi4l_m_awaddr  = awaddr_q;
  assign axi4l_m_awprot  = 3'b000;
  assign axi4l_m_awvalid = awvalid_q;
  assign axi4l_m_wdata   = wdata_q;
  assign axi4l_m_wstrb   = wstrb_q;
  assign axi4l_m_wvalid  = wvalid_q;
  assign axi4l_m_bready  = bready_q;
  assign axi4l_m_araddr  = araddr_q;
  assign axi4l_m_arprot  = 3'b000;
  assign axi4l_m_arvalid = arvalid_q;
  assign axi4l_m_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master
//   Drives axi4_lite_master through a table of directed transactions, a few
//   hand-written multi-cycle sequences and a randomized run. A configurable
//   AXI4-Lite slave with its own memory answers on the bus; expected results
//   come from the table constants or from a command-level memory model.
// -----------------------------------------------------------------------------
module tb_axi4_lite_master;
  localparam int TO = 8;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_wr, timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [63:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi4_lite_master #(.ADDR_W(64), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .axi_clk(clk), .axi_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_wr(rsp_wr), .timeout(timeout),
    .axi4l_m_awaddr(awaddr), .axi4l_m_awprot(awprot), .axi4l_m_awvalid(awvalid),
    .axi4l_m_awready(awready), .axi4l_m_wdata(wdata), .axi4l_m_wstrb(wstrb),
    .axi4l_m_wvalid(wvalid), .axi4l_m_wready(wready), .axi4l_m_bresp(bresp),
    .axi4l_m_bvalid(bvalid), .axi4l_m_bready(bready), .axi4l_m_araddr(araddr),
    .axi4l_m_arprot(arprot), .axi4l_m_arvalid(arvalid), .axi4l_m_arready(arready),
    .axi4l_m_rdata(rdata), .axi4l_m_rresp(rresp), .axi4l_m_rvalid(rvalid),
    .axi4l_m_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- slave configuration and model ----------------
  int       cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  bit       cfg_ar_stall;
  logic [1:0] cfg_bresp, cfg_rresp;
  logic [31:0] smem [logic [63:0]];

  task automatic set_cfg(input int aw, input int w, input int b, input int ar,
                         input int r, input logic [1:0] br, input logic [1:0] rr);
    cfg_aw_dly = aw; cfg_w_dly = w; cfg_b_dly = b;
    cfg_ar_dly = ar; cfg_r_dly = r; cfg_bresp = br; cfg_rresp = rr;
  endtask

  initial begin
    bit s_aw_got, s_w_got, s_ar_got;
    int s_aw_cnt, s_w_cnt, s_b_cnt, s_ar_cnt, s_r_cnt;
    logic [63:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata, tmp;
    logic [3:0]  s_wstrb;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
    s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0; s_ar_cnt = 0; s_r_cnt = 0;
    s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
        s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0; s_ar_cnt = 0; s_r_cnt = 0;
      end else begin
        // B response once both AW and W were accepted
        if (s_aw_got && s_w_got) begin
          if (s_b_cnt >= cfg_b_dly) begin
            bvalid = 1; bresp = cfg_bresp;
            if (bready) begin
              if (cfg_bresp == 2'b00) begin
                tmp = smem.exists(s_awaddr) ? smem[s_awaddr] : 32'h0;
                for (int i = 0; i < 4; i++)
                  if (s_wstrb[i]) tmp[8*i +: 8] = s_wdata[8*i +: 8];
                smem[s_awaddr] = tmp;
              end
              s_aw_got = 0; s_w_got = 0; s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0;
            end
          end else begin
            bvalid = 0; s_b_cnt++;
          end
        end else bvalid = 0;
        if (awvalid && !s_aw_got) begin
          if (s_aw_cnt >= cfg_aw_dly) begin
            awready = 1; s_aw_got = 1; s_awaddr = awaddr;
          end else begin
            awready = 0; s_aw_cnt++;
          end
        end else awready = 0;
        if (wvalid && !s_w_got) begin
          if (s_w_cnt >= cfg_w_dly) begin
            wready = 1; s_w_got = 1; s_wdata = wdata; s_wstrb = wstrb;
          end else begin
            wready = 0; s_w_cnt++;
          end
        end else wready = 0;
        // R response after AR was accepted
        if (s_ar_got) begin
          if (s_r_cnt >= cfg_r_dly) begin
            rvalid = 1; rresp = cfg_rresp;
            rdata = smem.exists(s_araddr) ? smem[s_araddr] : 32'h0;
            if (rready) begin
              s_ar_got = 0; s_ar_cnt = 0; s_r_cnt = 0;
            end
          end else begin
            rvalid = 0; s_r_cnt++;
          end
        end else rvalid = 0;
        if (arvalid && !s_ar_got) begin
          if (!cfg_ar_stall && s_ar_cnt >= cfg_ar_dly) begin
            arready = 1; s_ar_got = 1; s_araddr = araddr;
          end else begin
            arready = 0; s_ar_cnt++;
          end
        end else arready = 0;
      end
    end
  end

  // ---------------- command-level reference model ----------------
  logic [31:0] model_mem [logic [63:0]];

  function automatic logic [31:0] model_get(input logic [63:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    model_mem[a] = (model_get(a) & ~mask) | (d & mask);
  endtask

  // Response arrives 3 cycles after acceptance plus slave wait states;
  // AW and W waits overlap.
  function automatic int model_lat(input bit w, input int aw, input int wd,
                                   input int b, input int ar, input int r);
    if (w) return 3 + ((aw > wd) ? aw : wd) + b;
    return 3 + ar + r;
  endfunction

  // ---------------- transaction driver ----------------
  logic        tr_awv [0:127];
  logic        tr_wv  [0:127];
  logic        tr_br  [0:127];
  logic [63:0] tr_awa [0:127];

  task automatic do_cmd(input bit wr, input logic [63:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold, input bit present_next,
                        output logic [31:0] o_rdata, output logic [1:0] o_resp,
                        output logic o_wr, output logic o_to, output int lat);
    int cyc, n;
    o_rdata = 'x; o_resp = 'x; o_wr = 'x; o_to = 'x; lat = -1;
    cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin
      chk("cmd_accept_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    cyc = 1;
    tr_awv[1] = awvalid; tr_wv[1] = wvalid; tr_br[1] = bready; tr_awa[1] = awaddr;
    chk("timeout_clear_on_accept", 64'(timeout), 64'd0);
    if (wr) begin
      chk("awvalid_n1", 64'(awvalid), 64'd1);
      chk("wvalid_n1", 64'(wvalid), 64'd1);
      chk("awaddr_n1", awaddr, addr);
      chk("wdata_n1", 64'(wdata), 64'(wd));
      chk("wstrb_n1", 64'(wstrb), 64'(ws));
    end else begin
      chk("arvalid_n1", 64'(arvalid), 64'd1);
      chk("araddr_n1", araddr, addr);
    end
    while (!rsp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      tr_awv[cyc] = awvalid; tr_wv[cyc] = wvalid; tr_br[cyc] = bready; tr_awa[cyc] = awaddr;
    end
    if (!rsp_valid) begin
      chk("rsp_valid_wait", 64'(rsp_valid), 64'd1);
      return;
    end
    lat = cyc; o_rdata = rsp_rdata; o_resp = rsp_resp; o_wr = rsp_wr; o_to = timeout;
    for (int h = 0; h < hold; h++) begin
      if (present_next) begin
        cmd_valid = 1; cmd_wr = 0; cmd_addr = addr; cmd_wstrb = 0;
      end
      @(posedge clk); #1;
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(o_rdata));
      chk("hold_rsp_resp", 64'(rsp_resp), 64'(o_resp));
      chk("hold_rsp_wr", 64'(rsp_wr), 64'(o_wr));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_no_new_req", 64'({awvalid, arvalid}), 64'd0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_rise", 64'(cmd_ready), 64'd1);
    n_txn++;
    $display("txn %0d: %s addr=%h wdata=%h wstrb=%h -> rdata=%h resp=%0d wr=%0d to=%0d lat=%0d",
             n_txn, wr ? "WR" : "RD", addr, wd, ws, o_rdata, o_resp, o_wr, o_to, lat);
  endtask

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw, w, b, ar, r;
    logic [1:0]  bresp, rresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
    bit          exp_to;
  } vec_t;

  vec_t vecs [11];

  initial begin : main
    logic [31:0] g_rdata;
    logic [1:0]  g_resp;
    logic        g_wr, g_to;
    int          g_lat, n;

    vecs[0]  = '{1, 64'h10,   32'h00FF8800, 4'hF, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h0,        2'd0, 3,  0};
    vecs[1]  = '{1, 64'h1FFC, 32'h00123456, 4'hF, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h0,        2'd0, 3,  0};
    vecs[2]  = '{0, 64'h1FFC, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h00123456, 2'd0, 3,  0};
    vecs[3]  = '{1, 64'h20,   32'hAABBCCDD, 4'h5, 2, 0, 1, 0, 0, 2'd0, 2'd0, 32'h0,        2'd0, 6,  0};
    vecs[4]  = '{0, 64'h20,   32'h0,        4'h0, 0, 0, 0, 1, 2, 2'd0, 2'd0, 32'h00BB00DD, 2'd0, 6,  0};
    vecs[5]  = '{1, 64'h30,   32'hDEADBEEF, 4'hF, 0, 3, 0, 0, 0, 2'd2, 2'd0, 32'h0,        2'd2, 6,  0};
    vecs[6]  = '{0, 64'h40,   32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 32'h0,        2'd3, 3,  0};
    vecs[7]  = '{1, 64'h44,   32'h11223344, 4'hF, 6, 0, 2, 0, 0, 2'd0, 2'd0, 32'h0,        2'd0, 11, 1};
    vecs[8]  = '{0, 64'h44,   32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h11223344, 2'd0, 3,  0};
    vecs[9]  = '{0, 64'h10,   32'h0,        4'h0, 0, 0, 0, 2, 3, 2'd0, 2'd0, 32'h00FF8800, 2'd0, 8,  0};
    vecs[10] = '{0, 64'h1FFC, 32'h0,        4'h0, 0, 0, 0, 3, 3, 2'd0, 2'd0, 32'h00123456, 2'd0, 9,  1};

    rst = 1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; cfg_ar_stall = 0;
    set_cfg(0, 0, 0, 0, 0, 2'd0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;

    // reset state
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_rsp", 64'({rsp_rdata, rsp_resp, rsp_wr}), 64'd0);
    chk("rst_awaddr", awaddr, 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_wdata_wstrb", 64'({wdata, wstrb}), 64'd0);
    chk("rst_prot", 64'({awprot, arprot}), 64'd0);

    // directed table
    for (int i = 0; i < 11; i++) begin
      set_cfg(vecs[i].aw, vecs[i].w, vecs[i].b, vecs[i].ar, vecs[i].r, vecs[i].bresp, vecs[i].rresp);
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 0,
             g_rdata, g_resp, g_wr, g_to, g_lat);
      chk($sformatf("vec%0d_rdata", i), 64'(g_rdata), 64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_resp", i), 64'(g_resp), 64'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_wr", i), 64'(g_wr), 64'(vecs[i].wr));
      chk($sformatf("vec%0d_lat", i), 64'(g_lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_timeout", i), 64'(g_to), 64'(vecs[i].exp_to));
      if (vecs[i].wr && vecs[i].bresp == 2'd0) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
    end

    // awready delayed 3 cycles, wready immediate
    set_cfg(3, 0, 0, 0, 0, 2'd0, 2'd0);
    do_cmd(1, 64'h60, 32'h00ABCDEF, 4'hF, 0, 0, g_rdata, g_resp, g_wr, g_to, g_lat);
    model_write(64'h60, 32'h00ABCDEF, 4'hF);
    chk("awdly_lat", 64'(g_lat), 64'd6);
    chk("awdly_wvalid_c2", 64'(tr_wv[2]), 64'd0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("awdly_awvalid_c%0d", c), 64'(tr_awv[c]), 64'd1);
      chk($sformatf("awdly_awaddr_c%0d", c), tr_awa[c], 64'h60);
      chk($sformatf("awdly_bready_c%0d", c), 64'(tr_br[c]), 64'd0);
    end
    chk("awdly_awvalid_c5", 64'(tr_awv[5]), 64'd0);
    chk("awdly_bready_c5", 64'(tr_br[5]), 64'd1);
    repeat (3) begin
      chk("awdly_single_rsp", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
    end

    // rsp_ready held low 5 cycles with the next command already presented
    set_cfg(0, 0, 0, 0, 0, 2'd0, 2'd0);
    do_cmd(0, 64'h1FFC, 32'h0, 4'h0, 5, 1, g_rdata, g_resp, g_wr, g_to, g_lat);
    chk("hold_rdata", 64'(g_rdata), 64'h00123456);
    do_cmd(0, 64'h1FFC, 32'h0, 4'h0, 0, 0, g_rdata, g_resp, g_wr, g_to, g_lat);
    chk("after_hold_rdata", 64'(g_rdata), 64'h00123456);
    chk("after_hold_lat", 64'(g_lat), 64'd3);

    // arready withheld: timeout at the 8th busy cycle, then SLVERR read
    cfg_ar_stall = 1;
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 64'h50;
    @(posedge clk); #1;
    cmd_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 7) chk("to_cycle7", 64'(timeout), 64'd0);
      if (k == 8) chk("to_cycle8", 64'(timeout), 64'd1);
      if (k == 10) chk("to_arvalid_held", 64'(arvalid), 64'd1);
      @(posedge clk); #1;
    end
    cfg_ar_stall = 0; cfg_rresp = 2'b10;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_resp", 64'(rsp_resp), 64'd2);
    chk("to_rsp_wr", 64'(rsp_wr), 64'd0);
    chk("to_sticky", 64'(timeout), 64'd1);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("to_sticky_idle", 64'(timeout), 64'd1);
    set_cfg(0, 0, 0, 0, 0, 2'd0, 2'd0);
    do_cmd(0, 64'h44, 32'h0, 4'h0, 0, 0, g_rdata, g_resp, g_wr, g_to, g_lat);
    chk("to_cleared_rsp", 64'(g_to), 64'd0);
    chk("to_cleared_rdata", 64'(g_rdata), 64'h11223344);

    // reset while waiting in WR_RESP
    set_cfg(0, 0, 20, 0, 0, 2'd0, 2'd0);
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 64'h70; cmd_wdata = 32'h00777777; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    while (!bready && n < 10) begin @(posedge clk); #1; n++; end
    chk("rstmid_bready_seen", 64'(bready), 64'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("rstmid_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
    chk("rstmid_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    set_cfg(0, 0, 0, 0, 0, 2'd0, 2'd0);
    chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
    do_cmd(0, 64'h70, 32'h0, 4'h0, 0, 0, g_rdata, g_resp, g_wr, g_to, g_lat);
    chk("rstmid_read_rdata", 64'(g_rdata), 64'(model_get(64'h70)));
    chk("rstmid_read_resp", 64'(g_resp), 64'd0);
    chk("rstmid_read_lat", 64'(g_lat), 64'd3);

    // randomized traffic against the command-level model
    for (int t = 0; t < 40; t++) begin
      bit          r_wr;
      logic [63:0] r_addr;
      logic [31:0] r_wd;
      logic [3:0]  r_ws;
      int          aw, w, b, ar, r, e_lat;
      logic [1:0]  br, rr;
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 64'h100 + 64'(4 * $urandom_range(0, 7));
      r_wd   = $urandom;
      r_ws   = 4'($urandom_range(1, 15));
      aw = $urandom_range(0, 3); w = $urandom_range(0, 3); b = $urandom_range(0, 3);
      ar = $urandom_range(0, 3); r = $urandom_range(0, 3);
      br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      set_cfg(aw, w, b, ar, r, br, rr);
      e_lat = model_lat(r_wr, aw, w, b, ar, r);
      do_cmd(r_wr, r_addr, r_wd, r_ws, $urandom_range(0, 2), 0,
             g_rdata, g_resp, g_wr, g_to, g_lat);
      chk("rnd_rdata", 64'(g_rdata), r_wr ? 64'd0 : 64'(model_get(r_addr)));
      chk("rnd_resp", 64'(g_resp), r_wr ? 64'(br) : 64'(rr));
      chk("rnd_wr", 64'(g_wr), 64'(r_wr));
      chk("rnd_lat", 64'(g_lat), 64'(e_lat));
      chk("rnd_timeout", 64'(g_to), 64'((e_lat - 1) >= TO));
      if (r_wr && br == 2'd0) model_write(r_addr, r_wd, r_ws);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into AXI4-Lite write and read transactions.
- It is the initiator end of the axi4l_s_* interface that feeds the LED frame RAM.
- Used on-chip, e.g. by a pattern generator or frame loader, to write pixels into the display RAM (24-bit RGB in the low bits of 32-bit data) and read them back without a CPU.

Parameters:
- ADDR_W, 64, AXI address width; matches the slave's awaddr/araddr.
- DATA_W, 32, AXI data width; fixed at 32 for AXI4-Lite.
- TIMEOUT_CYCLES, 1024, cycles a transaction may remain outstanding before the sticky timeout flag sets; must be at least 2.

Ports:
- axi_clk  in  1  clock
- axi_rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle and able to accept a command
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  BRESP or RRESP as returned by the slave
- rsp_wr  out  1  response belongs to a write
- timeout  out  1  sticky flag: the current or most recent transaction exceeded TIMEOUT_CYCLES
- axi4l_m_awaddr  out  ADDR_W
- axi4l_m_awprot  out  3  constant 3'b000
- axi4l_m_awvalid  out  1
- axi4l_m_awready  in  1
- axi4l_m_wdata  out  32
- axi4l_m_wstrb  out  4
- axi4l_m_wvalid  out  1
- axi4l_m_wready  in  1
- axi4l_m_bresp  in  2
- axi4l_m_bvalid  in  1
- axi4l_m_bready  out  1
- axi4l_m_araddr  out  ADDR_W
- axi4l_m_arprot  out  3  constant 3'b000
- axi4l_m_arvalid  out  1
- axi4l_m_arready  in  1
- axi4l_m_rdata  in  32
- axi4l_m_rresp  in  2
- axi4l_m_rvalid  in  1
- axi4l_m_rready  out  1

Behaviour:
- Clocking and reset: single clock axi_clk; axi_rst is synchronous, active-high.
- Reset values:
  - cmd_ready = 1.
  - All AXI valid/ready outputs, rsp_valid and timeout = 0.
  - rsp_rdata, rsp_resp, rsp_wr and all address/data/strobe outputs = 0.
  - State = IDLE.
- All outputs are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, HOLD.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch the command, drop cmd_ready and clear timeout.
  - Write: next cycle awvalid = wvalid = 1 with the latched address, data and strobe; go to WR_REQ.
  - Read: next cycle arvalid = 1; go to RD_REQ.
- WR_REQ:
  - AW and W complete independently.
  - awvalid drops the cycle after awvalid & awready; wvalid drops the cycle after wvalid & wready.
  - The two handshakes may land in the same cycle or in either order.
  - When both are complete, assert bready and go to WR_RESP.
  - A valid is never deasserted before its handshake, and address/data are stable while valid is high.
- WR_RESP:
  - On bvalid & bready: capture bresp, set rsp_wr = 1 and rsp_rdata = 0.
  - Drop bready and assert rsp_valid the next cycle; go to HOLD.
- RD_REQ: on arvalid & arready, drop arvalid and assert rready next cycle; go to RD_RESP.
- RD_RESP:
  - On rvalid & rready: capture rdata and rresp, set rsp_wr = 0.
  - Drop rready and assert rsp_valid next cycle; go to HOLD.
- HOLD:
  - rsp_valid stays high and rsp_* stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, rsp_valid drops, cmd_ready rises and the FSM returns to IDLE.
  - The next command can therefore be accepted one cycle later.
- Minimum latency with a zero-wait slave (all ready signals high, response valid on the cycle after the handshake):
  - Write: command accepted at cycle N; AW/W handshake at N+1; B handshake at N+2; rsp_valid at N+3.
  - Read: AR handshake at N+1; R handshake at N+2; rsp_valid at N+3.
- Only one transaction is outstanding at a time.
- Timeout counter:
  - Saturating; clears on command acceptance and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches TIMEOUT_CYCLES, timeout sets and stays set until the next command is accepted or reset.
  - The transaction is not aborted; the master keeps waiting, as the protocol requires.
- Non-OKAY responses (SLVERR, DECERR) are passed through on rsp_resp with no retry.
- A bvalid or rvalid that arrives while the FSM is not waiting for it is ignored, because the corresponding ready signal is low.
- Reset mid-transaction: all valid outputs drop in the cycle after axi_rst is sampled and any pending response is discarded. The slave is expected to be reset together with the master.

Test Plan:
- Zero-wait write: cmd addr 0x10, wdata 0x00FF8800, wstrb 0xF. Required: awaddr 0x10, wdata 0x00FF8800 and wstrb 0xF on the AW/W handshake at N+1; rsp_valid at N+3 with rsp_resp 0, rsp_wr 1, rsp_rdata 0.
- Write then read back, address 0x1FFC, data 0x00123456: rsp_rdata 0x00123456, rsp_resp 0, rsp_wr 0.
- awready delayed 3 cycles with wready immediate: wvalid drops after one cycle; awvalid and awaddr stay stable for all 3 cycles; bready rises only after AW completes; exactly one response.
- rsp_ready held low for 5 cycles: rsp_* stable throughout; cmd_ready stays 0; a cmd_valid presented during that time is not accepted until 1 cycle after the rsp handshake.
- Slave never asserts arready, TIMEOUT_CYCLES = 8: timeout = 1 at the 8th outstanding cycle; arvalid stays high. Then release arready and return rresp 2'b10: rsp_resp 2'b10, timeout still 1. timeout clears on the next command accept.
- axi_rst asserted while in WR_RESP: the next cycle shows all valid outputs 0, cmd_ready 1, no rsp_valid; a following read completes normally.
